// File: rtl/main_exp32_pkg.sv
// Shared definitions for the main_exp32 execute stage: data width, ALUop
// classes, R-type funct codes and the decoded ALU operation enum.
package main_exp32_pkg;

    localparam int DATA_W = 32;

    // Operation classes carried on ALUop. Both 2'b10 and 2'b11 are R-type.
    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    // R-type funct codes (low six bits of the sign-extended immediate).
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    // Decoded ALU operation. NONE forces a zero result.
    typedef enum logic [2:0] {
        ADD,
        SUB,
        AND,
        OR,
        SLT,
        NONE
    } alu_ctl_t;

    // True when every bit of the word is clear.
    function automatic logic is_all_zero(input logic [DATA_W-1:0] value);
        return (value == '0);
    endfunction

endpackage

// File: rtl/main_exp32_alu_ctl.sv
// ALU control decoder: maps the operation class and the R-type funct field
// onto a single ALU operation. Purely combinational.
module main_exp32_alu_ctl
    import main_exp32_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output alu_ctl_t   alu_ctl
);

    // Memory class always adds, branch class always subtracts; anything with
    // the upper ALUop bit set looks at the full funct field.
    always_comb begin
        alu_ctl = NONE;
        case (alu_op)
            ALUOP_MEM: alu_ctl = ADD;
            ALUOP_BEQ: alu_ctl = SUB;
            default: begin
                case (funct)
                    F_ADD:   alu_ctl = ADD;
                    F_SUB:   alu_ctl = SUB;
                    F_AND:   alu_ctl = AND;
                    F_OR:    alu_ctl = OR;
                    F_SLT:   alu_ctl = SLT;
                    default: alu_ctl = NONE;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/main_exp32.sv
// Registered 32-bit execute stage. Selects operand B, performs the decoded
// ALU operation and registers the result, the operand B actually used and a
// zero flag on a single clock edge. External vectors use bit 0 as the MSB.
module main_exp32
    import main_exp32_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [0:1]  ALUop,
    input  logic [0:31] RD1,
    input  logic [0:31] RD2,
    input  logic [0:31] SE,
    output logic        Zero,
    output logic [0:31] Out,
    output logic [0:31] Out2
);

    logic [1:0]        alu_op;
    logic [5:0]        funct;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] rd2_val;
    logic [DATA_W-1:0] se_val;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] result;
    alu_ctl_t          alu_ctl;

    logic [DATA_W-1:0] out_d;
    logic [DATA_W-1:0] out_q;
    logic [DATA_W-1:0] out2_d;
    logic [DATA_W-1:0] out2_q;
    logic              zero_d;
    logic              zero_q;

    // Whole-vector assignments keep MSB on MSB, so the ascending external
    // ranges map straight onto descending internal ones.
    assign alu_op  = ALUop;
    assign funct   = SE[26:31];
    assign op_a    = RD1;
    assign rd2_val = RD2;
    assign se_val  = SE;

    main_exp32_alu_ctl u_alu_ctl (
        .alu_op  (alu_op),
        .funct   (funct),
        .alu_ctl (alu_ctl)
    );

    // Loads and stores add the immediate; every other class uses rt.
    always_comb begin
        op_b = rd2_val;
        if (alu_op == ALUOP_MEM) begin
            op_b = se_val;
        end
    end

    // ALU proper. SLT uses a genuine signed compare so that operands whose
    // difference overflows still order correctly.
    always_comb begin
        result = '0;
        case (alu_ctl)
            ADD:     result = op_a + op_b;
            SUB:     result = op_a - op_b;
            AND:     result = op_a & op_b;
            OR:      result = op_a | op_b;
            SLT:     result = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
            default: result = '0;
        endcase
    end

    // Next values for the output registers; the zero flag is derived from
    // the same result word so it always agrees with Out.
    always_comb begin
        out_d  = result;
        out2_d = op_b;
        zero_d = is_all_zero(result);
    end

    // Output registers. Reset wins over the data path and clears the
    // in-flight operation, leaving a zero result with Zero asserted.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q  <= '0;
            out2_q <= '0;
            zero_q <= 1'b1;
        end else begin
            out_q  <= out_d;
            out2_q <= out2_d;
            zero_q <= zero_d;
        end
    end

    assign Out  = out_q;
    assign Out2 = out2_q;
    assign Zero = zero_q;

endmodule

// File: tb/tb_main_exp32.sv
// Self-checking bench for main_exp32. Stimulus pushes hand-computed
// expectations into a queue; a monitor pops one per clock edge and compares.
module tb_main_exp32;

    typedef struct {
        logic [31:0] out;
        logic [31:0] out2;
        logic        zero;
        string       name;
    } expect_t;

    logic        clk;
    logic        reset;
    logic [0:1]  ALUop;
    logic [0:31] RD1;
    logic [0:31] RD2;
    logic [0:31] SE;
    logic        Zero;
    logic [0:31] Out;
    logic [0:31] Out2;

    expect_t exp_q[$];
    int      errors;
    int      checks;

    main_exp32 dut (
        .clk   (clk),
        .reset (reset),
        .ALUop (ALUop),
        .RD1   (RD1),
        .RD2   (RD2),
        .SE    (SE),
        .Zero  (Zero),
        .Out   (Out),
        .Out2  (Out2)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare the current DUT outputs against one expected entry.
    task automatic checkOutput(input expect_t e);
        checks++;
        if (Out !== e.out || Out2 !== e.out2 || Zero !== e.zero) begin
            errors++;
            $display("[TB] FAIL %s: got Out=%h Out2=%h Zero=%b, expected Out=%h Out2=%h Zero=%b",
                     e.name, Out, Out2, Zero, e.out, e.out2, e.zero);
        end
    endtask

    // Drive one vector away from the rising edge and queue its expectation.
    task automatic applyStimulus(input logic rst, input logic [1:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] se,
                                 input logic [31:0] exp_out, input logic [31:0] exp_out2,
                                 input logic exp_zero, input string name);
        expect_t e;
        @(negedge clk);
        reset = rst;
        ALUop = op;
        RD1   = a;
        RD2   = b;
        SE    = se;
        e.out  = exp_out;
        e.out2 = exp_out2;
        e.zero = exp_zero;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: every rising edge presents a new output; check it 1 ns later.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                checkOutput(exp_q.pop_front());
            end
        end
    end

    // Global time bound so the bench always terminates.
    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        expect_t hold;
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        ALUop  = 2'b00;
        RD1    = '0;
        RD2    = '0;
        SE     = '0;

        // Reset state.
        applyStimulus(1'b1, 2'b00, 32'd3, 32'd4, 32'd5, 32'd0, 32'd0, 1'b1, "reset_state");

        // R-type, one funct per cycle.
        applyStimulus(1'b0, 2'b10, 32'd5, 32'd6, 32'h20, 32'd11,        32'd6, 1'b0, "rtype_add");
        applyStimulus(1'b0, 2'b10, 32'd5, 32'd6, 32'h22, 32'hFFFFFFFF,  32'd6, 1'b0, "rtype_sub");
        applyStimulus(1'b0, 2'b10, 32'd5, 32'd6, 32'h24, 32'd4,         32'd6, 1'b0, "rtype_and");
        applyStimulus(1'b0, 2'b10, 32'd5, 32'd6, 32'h25, 32'd7,         32'd6, 1'b0, "rtype_or");
        applyStimulus(1'b0, 2'b10, 32'd5, 32'd6, 32'h2A, 32'd1,         32'd6, 1'b0, "rtype_slt");
        applyStimulus(1'b0, 2'b11, 32'd5, 32'd6, 32'h25, 32'd7,         32'd6, 1'b0, "aluop11_or");

        // Signed SLT, including an overflowing difference.
        applyStimulus(1'b0, 2'b10, 32'hFFFFFFFF, 32'd1, 32'h2A, 32'd1, 32'd1, 1'b0, "slt_neg_lt_pos");
        applyStimulus(1'b0, 2'b10, 32'd1, 32'hFFFFFFFF, 32'h2A, 32'd0, 32'hFFFFFFFF, 1'b1, "slt_pos_gt_neg");
        applyStimulus(1'b0, 2'b10, 32'h80000000, 32'h7FFFFFFF, 32'h2A, 32'd1, 32'h7FFFFFFF, 1'b0, "slt_overflow");

        // Memory and branch classes; RD2 must be ignored for ALUop=00.
        applyStimulus(1'b0, 2'b00, 32'd5, 32'd99, 32'd8,  32'd13,  32'd8,  1'b0, "mem_add_imm");
        applyStimulus(1'b0, 2'b00, 32'd5, 32'd99, 32'h22, 32'h27,  32'h22, 1'b0, "mem_ignores_funct");
        applyStimulus(1'b0, 2'b01, 32'd6, 32'd6, 32'h1234, 32'd0,  32'd6,  1'b1, "beq_equal");
        applyStimulus(1'b0, 2'b01, 32'd7, 32'd6, 32'h1234, 32'd1,  32'd6,  1'b0, "beq_not_equal");

        // Wrap-around and unknown funct.
        applyStimulus(1'b0, 2'b10, 32'hFFFFFFFF, 32'd1, 32'h20, 32'd0, 32'd1, 1'b1, "add_wrap");
        applyStimulus(1'b0, 2'b10, 32'd5, 32'd6, 32'h27, 32'd0, 32'd6, 1'b1, "unknown_funct");

        // Reset mid-stream of adds, then first result one edge after release.
        applyStimulus(1'b0, 2'b10, 32'd10, 32'd20, 32'h20, 32'd30, 32'd20, 1'b0, "stream_add1");
        applyStimulus(1'b1, 2'b10, 32'd11, 32'd20, 32'h20, 32'd0,  32'd0,  1'b1, "reset_midstream");
        applyStimulus(1'b0, 2'b10, 32'd12, 32'd20, 32'h20, 32'd32, 32'd20, 1'b0, "first_after_reset");

        // Latency: inputs changed mid-cycle must not disturb the outputs.
        applyStimulus(1'b0, 2'b10, 32'd5, 32'd6, 32'h25, 32'd7, 32'd6, 1'b0, "latency_base");
        @(posedge clk);
        #3;
        ALUop = 2'b00;
        RD1   = 32'd100;
        RD2   = 32'd1;
        SE    = 32'd50;
        #1;
        hold.out  = 32'd7;
        hold.out2 = 32'd6;
        hold.zero = 1'b0;
        hold.name = "latency_hold";
        checkOutput(hold);
        applyStimulus(1'b0, 2'b00, 32'd100, 32'd1, 32'd50, 32'd150, 32'd50, 1'b0, "latency_update");

        // Drain the scoreboard; anything left over is a failure.
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
